// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation classes and the mux/immediate encodings seen by the datapath.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction funct fields onto the
// 3-bit ALU control code.
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can select sub; addi ignores funct7b5.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, driving every mux select and write enable.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic [1:0]  immSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  resultSrc,
    output logic        adrSrc,
    output logic [2:0]  aluControl,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        regWrite,
    output logic        memWrite,
    output logic        illegal
);

    state_t  state_reg, state_next;
    alu_op_t alu_op;
    logic    ir_write_raw, pc_write_raw, reg_write_raw, mem_write_raw, illegal_raw;
    logic    branch_taken;

    assign branch_taken = SUPPORT_BNE ? (zero ^ funct3[0]) : zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BR:        state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        aluSrcA       = 2'b00;
        aluSrcB       = 2'b00;
        resultSrc     = 2'b00;
        adrSrc        = 1'b0;
        alu_op        = ALUOP_ADD;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                aluSrcB      = 2'b10;
                resultSrc    = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_DECODE: begin
                aluSrcA     = 2'b01;
                aluSrcB     = 2'b01;
                illegal_raw = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL});
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                aluSrcA      = 2'b10;
                alu_op       = ALUOP_SUB;
                pc_write_raw = branch_taken;
            end
            S_JAL: begin
                aluSrcA      = 2'b01;
                aluSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are killed while reset is high so an aborted instruction commits nothing.
    assign irWrite  = ir_write_raw  & ~reset;
    assign pcWrite  = pc_write_raw  & ~reset;
    assign regWrite = reg_write_raw & ~reset;
    assign memWrite = mem_write_raw & ~reset;
    assign illegal  = illegal_raw   & ~reset;
    assign immSrc   = imm_src_for(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (aluControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction scenarios plus
// randomized instruction streams checked cycle by cycle against a reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immSrc, aluSrcA, aluSrcB, resultSrc;
    logic       adrSrc;
    logic [2:0] aluControl;
    logic       irWrite, pcWrite, regWrite, memWrite, illegal;

    int checks   = 0;
    int failures = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .immSrc(immSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .resultSrc(resultSrc), .adrSrc(adrSrc), .aluControl(aluControl),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
        .memWrite(memWrite), .illegal(illegal)
    );

    function automatic logic [16:0] actual_vec();
        return {immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
                irWrite, pcWrite, regWrite, memWrite, illegal};
    endfunction

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int latency_of(input int k);
        case (k)
            K_LW:    return 5;
            K_BR:    return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs for cycle cyc (0 = fetch) of an instruction of kind k.
    function automatic logic [16:0] expected_vec(input int k, input int cyc, input logic [6:0] o,
                                                 input logic [2:0] f3, input logic f7, input logic z);
        logic [1:0] imm, sa, sb, rs;
        logic       adr, irw, pcw, rw, mw, ill;
        logic [2:0] ac;
        imm = (k == K_SW) ? 2'd1 : (k == K_BR) ? 2'd2 : (k == K_JAL) ? 2'd3 : 2'd0;
        sa = 0; sb = 0; rs = 0; adr = 0; ac = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
        if (cyc == 0) begin
            sb = 2; rs = 2; irw = 1; pcw = 1;
        end else if (cyc == 1) begin
            sa = 1; sb = 1; ill = (k == K_ILL);
        end else begin
            case (k)
                K_LW, K_SW: begin
                    if (cyc == 2) begin sa = 2; sb = 1; end
                    else if (cyc == 3) begin adr = 1; mw = (k == K_SW); end
                    else begin rs = 1; rw = 1; end
                end
                K_R, K_I: begin
                    if (cyc == 2) begin sa = 2; sb = (k == K_I) ? 2'd1 : 2'd0; ac = funct_alu(f3, o[5], f7); end
                    else rw = 1;
                end
                K_BR: begin sa = 2; ac = 3'd1; pcw = z ^ f3[0]; end
                K_JAL: begin
                    if (cyc == 2) begin sa = 1; sb = 2; pcw = 1; end
                    else rw = 1;
                end
                default: ;
            endcase
        end
        return {imm, sa, sb, rs, adr, ac, irw, pcw, rw, mw, ill};
    endfunction

    // Called right after a posedge with the DUT in FETCH; returns just after the
    // posedge ending the instruction. zmode<0 randomizes zero every cycle.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int zmode, input int ncyc);
        int k, lat, bad;
        logic [16:0] exp_v, act_v;
        k = kind_of(o);
        lat = latency_of(k);
        if (ncyc > 0 && ncyc < lat) lat = ncyc;
        bad = 0;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int c = 0; c < lat; c++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            exp_v = expected_vec(k, c, o, f3, f7, zero);
            act_v = actual_vec();
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                bad++;
                $display("FAIL %s cyc%0d op=%b f3=%b f7=%b z=%b actual=%b required=%b",
                         name, c, o, f3, f7, zero, act_v, exp_v);
            end
            @(posedge clk); #1;
        end
        $display("txn %s op=%b f3=%b f7=%b cycles=%0d errors=%0d", name, o, f3, f7, lat, bad);
    endtask

    task automatic check_in_reset(input string name);
        logic [16:0] exp_v;
        @(negedge clk);
        exp_v = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 5'b00000};
        checks++;
        if (actual_vec() !== exp_v || regWrite !== 1'b0) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, actual_vec(), exp_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        #2;
        check_in_reset("reset_state");
        check_in_reset("reset_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_lw();
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, -1, 0);
    endtask

    task automatic test_sw();
        run_instr("sw", 7'b0100011, 3'b010, 1'b1, -1, 0);
    endtask

    task automatic test_alu();
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, -1, 0);
        run_instr("addi", 7'b0010011, 3'b000, 1'b1, -1, 0);
        run_instr("slt", 7'b0110011, 3'b010, 1'b0, -1, 0);
        run_instr("ori", 7'b0010011, 3'b110, 1'b0, -1, 0);
        run_instr("and", 7'b0110011, 3'b111, 1'b0, -1, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1, 0);
        run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 0, 0);
        run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 0, 0);
        run_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1, 0);
    endtask

    task automatic test_jal();
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, -1, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal0", 7'b0000000, 3'b000, 1'b0, -1, 0);
        run_instr("illegal_ff", 7'b1111111, 3'b111, 1'b1, -1, 0);
    endtask

    task automatic test_reset_abort();
        run_instr("lw_part", 7'b0000011, 3'b010, 1'b0, -1, 3);
        #2 reset = 1'b1;
        check_in_reset("abort_memread");
        @(posedge clk); #1;
        check_in_reset("abort_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("lw_after_abort", 7'b0000011, 3'b010, 1'b0, -1, 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6];
        logic [6:0] o;
        int sel;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 6);
            if (sel == 6) begin
                do o = 7'($urandom_range(0, 127)); while (kind_of(o) != K_ILL);
            end else begin
                o = ops[sel];
            end
            run_instr("rand", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
